// File: rtl/dvi_rx_tmds_aligner_if.sv
// Lane bundle between deserializer, aligner and TMDS decoder.
// relock_count is present only when DVI_RX_ALIGN_STATS_EN is defined.
interface dvi_rx_tmds_aligner_if;
  logic [9:0] raw_data;
  logic [9:0] symbol;
  logic       symbol_ctrl;
  logic       locked;
  logic [3:0] bit_offset;
`ifdef DVI_RX_ALIGN_STATS_EN
  logic [7:0] relock_count;

  modport master (
    output raw_data,
    input  symbol,
    input  symbol_ctrl,
    input  locked,
    input  bit_offset,
    input  relock_count
  );

  modport slave (
    input  raw_data,
    output symbol,
    output symbol_ctrl,
    output locked,
    output bit_offset,
    output relock_count
  );
`else
  modport master (
    output raw_data,
    input  symbol,
    input  symbol_ctrl,
    input  locked,
    input  bit_offset
  );

  modport slave (
    input  raw_data,
    output symbol,
    output symbol_ctrl,
    output locked,
    output bit_offset
  );
`endif
endinterface

// File: rtl/dvi_rx_tmds_aligner.sv
// TMDS lane word aligner: sweeps ten bit offsets for control-token runs, then frames symbols.
// Optional relock statistics counter enabled by DVI_RX_ALIGN_STATS_EN.
module dvi_rx_tmds_aligner #(
  parameter int unsigned CTRL_RUN       = 8,
  parameter int unsigned SEARCH_TIMEOUT = 2048,
  parameter int unsigned LOSS_TIMEOUT   = 8192
) (
  input logic                  pixel_clock,
  input logic                  reset,
  dvi_rx_tmds_aligner_if.slave lane
);

  localparam int unsigned IdleMax = (LOSS_TIMEOUT > SEARCH_TIMEOUT) ? LOSS_TIMEOUT : SEARCH_TIMEOUT;
  localparam int unsigned RunW    = $clog2(CTRL_RUN + 1);
  localparam int unsigned IdleW   = $clog2(IdleMax + 1);

  localparam logic [RunW-1:0]  RunLock    = RunW'(CTRL_RUN - 1);
  localparam logic [RunW-1:0]  RunSat     = RunW'(CTRL_RUN);
  localparam logic [IdleW-1:0] SearchLast = IdleW'(SEARCH_TIMEOUT - 1);
  localparam logic [IdleW-1:0] LossLast   = IdleW'(LOSS_TIMEOUT - 1);
  localparam logic [IdleW-1:0] IdleSat    = IdleW'(IdleMax);

  localparam logic [9:0] TokA = 10'b1101010100;
  localparam logic [9:0] TokB = 10'b0010101011;
  localparam logic [9:0] TokC = 10'b0101010100;
  localparam logic [9:0] TokD = 10'b1010101011;

  typedef enum logic [0:0] {StSearch, StLocked} state_e;

  state_e           state_q;
  logic [9:0]       q1_q, q2_q;
  logic [9:0]       symbol_q;
  logic             symbol_ctrl_q;
  logic             locked_q;
  logic [3:0]       bit_offset_q;
  logic [RunW-1:0]  run_q;
  logic [IdleW-1:0] idle_q;

  logic [9:0] cand;
  logic       tok;
  logic [3:0] offset_next;
  logic       lose;

  always_comb begin
    // Older word sits in the low half, so offset 0 passes q2 straight through.
    cand        = 10'(({q1_q, q2_q}) >> bit_offset_q);
    tok         = (cand == TokA) || (cand == TokB) || (cand == TokC) || (cand == TokD);
    offset_next = (bit_offset_q == 4'd9) ? 4'd0 : bit_offset_q + 4'd1;
    lose        = (state_q == StLocked) && !tok && (idle_q == LossLast);
  end

  always_ff @(posedge pixel_clock or posedge reset) begin
    if (reset) begin
      state_q       <= StSearch;
      q1_q          <= '0;
      q2_q          <= '0;
      symbol_q      <= '0;
      symbol_ctrl_q <= 1'b0;
      locked_q      <= 1'b0;
      bit_offset_q  <= '0;
      run_q         <= '0;
      idle_q        <= '0;
    end else begin
      q1_q          <= lane.raw_data;
      q2_q          <= q1_q;
      symbol_q      <= cand;
      symbol_ctrl_q <= tok;

      if (tok) begin
        idle_q <= '0;
        if (run_q != RunSat) run_q <= run_q + RunW'(1);
      end else begin
        run_q <= '0;
        if (idle_q != IdleSat) idle_q <= idle_q + IdleW'(1);
      end

      unique case (state_q)
        StSearch: begin
          if (tok && (run_q == RunLock)) begin
            state_q  <= StLocked;
            locked_q <= 1'b1;
          end else if (!tok && (idle_q == SearchLast)) begin
            bit_offset_q <= offset_next;
            idle_q       <= '0;
          end
        end
        StLocked: begin
          // Data symbols only age idle_q; only a long token drought drops lock.
          if (lose) begin
            state_q      <= StSearch;
            locked_q     <= 1'b0;
            idle_q       <= '0;
            bit_offset_q <= offset_next;
          end
        end
      endcase
    end
  end

  assign lane.symbol      = symbol_q;
  assign lane.symbol_ctrl = symbol_ctrl_q;
  assign lane.locked      = locked_q;
  assign lane.bit_offset  = bit_offset_q;

`ifdef DVI_RX_ALIGN_STATS_EN
  logic [7:0] relock_q;

  always_ff @(posedge pixel_clock or posedge reset) begin
    if (reset) begin
      relock_q <= '0;
    end else if (lose && (relock_q != 8'hff)) begin
      relock_q <= relock_q + 8'd1;
    end
  end

  assign lane.relock_count = relock_q;
`endif

endmodule

// File: tb/tb_dvi_rx_tmds_aligner.sv
// Randomized bench for dvi_rx_tmds_aligner against a token-timing reference model.
// Relock statistics are checked when DVI_RX_ALIGN_STATS_EN is defined.
module tb_dvi_rx_tmds_aligner;

  localparam int unsigned CtrlRun       = 8;
  localparam int unsigned SearchTimeout = 16;
  localparam int unsigned LossTimeout   = 32;
  localparam logic [9:0] Tokens [4] = '{10'b1101010100, 10'b0010101011,
                                        10'b0101010100, 10'b1010101011};

  logic pixel_clock = 1'b0;
  logic reset       = 1'b1;

  dvi_rx_tmds_aligner_if lane_if ();

  dvi_rx_tmds_aligner #(
    .CTRL_RUN      (CtrlRun),
    .SEARCH_TIMEOUT(SearchTimeout),
    .LOSS_TIMEOUT  (LossTimeout)
  ) dut (
    .pixel_clock(pixel_clock),
    .reset      (reset),
    .lane       (lane_if)
  );

  always #5 pixel_clock = ~pixel_clock;

  int n_checks = 0;
  int n_pass   = 0;
  int cycles   = 0;
  bit saw_lock = 1'b0;

  // Reference model: offset, token streak and time since the last token.
  logic [9:0] seen [$];
  int         m_off, m_streak, m_since;
  bit         m_locked, m_ctrl;
  logic [9:0] m_sym;
`ifdef DVI_RX_ALIGN_STATS_EN
  int         m_relocks;
`endif

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
  endtask

  function automatic bit is_token(input logic [9:0] w);
    for (int i = 0; i < 4; i++) if (w == Tokens[i]) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [9:0] rotl(input logic [9:0] w, input int k);
    logic [9:0] r;
    for (int j = 0; j < 10; j++) r[j] = w[(j - k + 10) % 10];
    return r;
  endfunction

  function automatic logic [9:0] rand_data();
    logic [9:0] d;
    do d = 10'($urandom); while (is_token(d));
    return d;
  endfunction

  task automatic model_reset();
    seen     = '{10'd0, 10'd0};
    m_off    = 0;
    m_streak = 0;
    m_since  = 0;
    m_locked = 1'b0;
    m_ctrl   = 1'b0;
    m_sym    = '0;
`ifdef DVI_RX_ALIGN_STATS_EN
    m_relocks = 0;
`endif
  endtask

  task automatic model_edge(input logic [9:0] word);
    logic [9:0] cand;
    int         p;
    int         limit;
    for (int i = 0; i < 10; i++) begin
      p = m_off + i;
      if (p < 10) cand[i] = seen[0][p];
      else        cand[i] = seen[1][p - 10];
    end
    seen.push_back(word);
    void'(seen.pop_front());
    m_sym  = cand;
    m_ctrl = is_token(cand);
    if (m_ctrl) begin
      m_since = 0;
      m_streak++;
      if (!m_locked && m_streak == CtrlRun) m_locked = 1'b1;
    end else begin
      m_streak = 0;
      limit = m_locked ? LossTimeout : SearchTimeout;
      if (m_since == limit - 1) begin
`ifdef DVI_RX_ALIGN_STATS_EN
        if (m_locked && m_relocks < 255) m_relocks++;
`endif
        m_locked = 1'b0;
        m_off    = (m_off + 1) % 10;
        m_since  = 0;
      end else begin
        m_since++;
      end
    end
  endtask

  task automatic step(input logic [9:0] word);
    lane_if.raw_data = word;
    @(posedge pixel_clock);
    model_edge(word);
    @(negedge pixel_clock);
    cycles++;
    check("symbol", lane_if.symbol, m_sym);
    check("symbol_ctrl", lane_if.symbol_ctrl, m_ctrl);
    check("locked", lane_if.locked, m_locked);
    check("bit_offset", lane_if.bit_offset, m_off);
`ifdef DVI_RX_ALIGN_STATS_EN
    check("relock_count", lane_if.relock_count, m_relocks);
`endif
    if (lane_if.locked) saw_lock = 1'b1;
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    lane_if.raw_data = '0;
    repeat (2) @(negedge pixel_clock);
    reset = 1'b0;
    model_reset();
    cycles   = 0;
    saw_lock = 1'b0;
  endtask

  task automatic run_until_lock(input logic [9:0] tok, input int k, input int limit,
                                output int at);
    at = -1;
    for (int i = 0; i < limit && at < 0; i++) begin
      step(rotl(tok, k));
      if (lane_if.locked) at = cycles;
    end
    check("lock_reached", lane_if.locked, 1);
  endtask

  // Lock on tokens framed for the model's current offset, then starve until lock drops.
  task automatic relock_cycle(input logic [9:0] tok);
    for (int i = 0; i < 100 && !lane_if.locked; i++) step(rotl(tok, m_off));
    check("relock_lock", lane_if.locked, 1);
    for (int i = 0; i < 100 && lane_if.locked; i++) step(10'd0);
    check("relock_loss", lane_if.locked, 0);
  endtask

  initial begin
    #3000000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1);
  end

  initial begin
    int lc;
    int hold;
    bit dropped;
    int k;
    int ti;

    apply_reset();
    check("rst_symbol", lane_if.symbol, 0);
    check("rst_symbol_ctrl", lane_if.symbol_ctrl, 0);
    check("rst_locked", lane_if.locked, 0);
    check("rst_bit_offset", lane_if.bit_offset, 0);
`ifdef DVI_RX_ALIGN_STATS_EN
    check("rst_relock_count", lane_if.relock_count, 0);
`endif

    // Stream rotated by 3: sweep 0,1,2 then lock on offset 3.
    run_until_lock(Tokens[0], 3, 200, lc);
    check("rot3_lock_cycle", lc, 3 * SearchTimeout + CtrlRun);
    check("rot3_offset", lane_if.bit_offset, 3);
    check("rot3_symbol", lane_if.symbol, Tokens[0]);
    check("rot3_ctrl", lane_if.symbol_ctrl, 1);

    for (int r = 0; r < 4; r++) begin
      k  = $urandom_range(0, 9);
      ti = $urandom_range(0, 3);
      apply_reset();
      run_until_lock(Tokens[ti], k, 400, lc);
      check("rand_lock_cycle", lc, (k == 0) ? CtrlRun + 2 : k * SearchTimeout + CtrlRun);
      check("rand_offset", lane_if.bit_offset, k);
      check("rand_symbol", lane_if.symbol, Tokens[ti]);
    end

    // Eight aligned tokens, then data until lock is lost.
    apply_reset();
    for (int i = 0; i < 8; i++) step(Tokens[i % 4]);
    lc = -1;
    hold = 0;
    dropped = 1'b0;
    for (int i = 0; i < 100; i++) begin
      step(rand_data());
      if (lc < 0) begin
        if (lane_if.locked) lc = cycles;
      end else if (!dropped) begin
        if (lane_if.locked) hold++;
        else begin
          dropped = 1'b1;
          check("drop_offset", lane_if.bit_offset, 1);
        end
      end
    end
    check("lock_at_token8", lc, CtrlRun + 2);
    check("hold_cycles", hold, LossTimeout - 1);
    check("dropped", dropped, 1);

    // Runs of 7 tokens broken by one data symbol never lock.
    apply_reset();
    for (int rep = 0; rep < 12; rep++) begin
      for (int i = 0; i < 7; i++) step(Tokens[$urandom_range(0, 3)]);
      step(rand_data());
    end
    check("no_lock_7of8", saw_lock, 0);

    // Asynchronous reset while locked.
    apply_reset();
    run_until_lock(Tokens[0], 0, 100, lc);
    @(posedge pixel_clock);
    #2;
    reset = 1'b1;
    #1;
    check("async_symbol", lane_if.symbol, 0);
    check("async_symbol_ctrl", lane_if.symbol_ctrl, 0);
    check("async_locked", lane_if.locked, 0);
    check("async_bit_offset", lane_if.bit_offset, 0);
    @(negedge pixel_clock);
    reset = 1'b0;
    model_reset();
    cycles = 0;
    run_until_lock(Tokens[3], 2, 400, lc);
    check("restart_lock_cycle", lc, 2 * SearchTimeout + CtrlRun);
    check("restart_offset", lane_if.bit_offset, 2);

    // Offset 9, then loss wraps the offset to 0.
    apply_reset();
    run_until_lock(Tokens[1], 9, 400, lc);
    check("off9_lock_cycle", lc, 9 * SearchTimeout + CtrlRun);
    check("off9_offset", lane_if.bit_offset, 9);
    check("off9_symbol", lane_if.symbol, Tokens[1]);
    for (int i = 0; i < 100 && lane_if.locked; i++) step(10'd0);
    check("off9_unlocked", lane_if.locked, 0);
    check("off9_wrap", lane_if.bit_offset, 0);

    apply_reset();
    for (int n = 0; n < 3; n++) relock_cycle(Tokens[n]);
`ifdef DVI_RX_ALIGN_STATS_EN
    check("relock_3", lane_if.relock_count, 3);
    for (int n = 0; n < 297; n++) relock_cycle(Tokens[n % 4]);
    check("relock_sat", lane_if.relock_count, 255);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
